branch_unit: RTL and testbench
==============================

// Module: branch_unit
// PURPOSE
//  Parametrised branch resolution unit for the multi-cycle RISC-V core; successor to the combinational branch decode.
//  Decodes all six B-type conditions, performs signed/unsigned compare, computes the next PC and flags mispredicts.
//  Holds a BHT of 2-bit saturating counters that provides fetch-time direction prediction. Sits beside the ALU in EX.
// PARAMETERS
//  XLEN       32     datapath / PC width
//  BHT_DEPTH  64     BHT entries; power of two, >=2
//  CNT_RESET  2'b01  counter value loaded on reset (weakly not-taken)
// PORTS
//  clk             in   1     core clock, all state on rising edge
//  rst_n           in   1     synchronous, active-low reset
//  req_valid       in   1     request qualifier
//  req_ready       out  1     unit can accept a request
//  op              in   7     instruction opcode
//  funct3          in   3     instruction funct3
//  branch          in   1     control-unit branch enable
//  rs1_val         in   XLEN  operand A
//  rs2_val         in   XLEN  operand B
//  pc              in   XLEN  PC of the instruction being resolved
//  imm             in   XLEN  sign-extended B-type immediate
//  pred_pc         in   XLEN  fetch-side lookup PC
//  pred_taken      out  1     combinational BHT prediction for pred_pc
//  res_valid       out  1     result strobe, exactly one cycle per request
//  res_taken       out  1     branch resolved taken
//  res_target      out  XLEN  next PC: pc+imm if taken, else pc+4
//  res_mispredict  out  1     resolved direction differs from prediction
//  res_illegal     out  1     branch opcode with funct3 010/011
// BEHAVIOUR
//  - Reset: FSM->IDLE; all res_* = 0; every BHT counter = CNT_RESET; req_ready = 1 from the first cycle after reset.
//  - FSM: IDLE -(req_valid)-> EVAL -> RESP -> IDLE. req_ready = 1 only in IDLE.
//  - Accept (IDLE & req_valid): capture op, funct3, branch, operands, pc, imm; also capture pred = BHT[idx(pc)][1].
//  - EVAL: register the compare and pc+imm / pc+4 sums. RESP: res_valid = 1 for one cycle with all res_* valid.
//  - Latency: accepted in cycle N -> res_valid in cycle N+2; throughput one request per 3 cycles.
//  - res_* hold their last values outside RESP; only res_valid qualifies them.
//  - is_br = (op==7'b1100011) & branch. Conditions: BEQ 000, BNE 001, BLT 100 signed, BGE 101 signed,
//    BLTU 110 unsigned, BGEU 111 unsigned.
//  - !is_br: taken = 0, target = pc+4, mispredict = 0, illegal = 0, no BHT update.
//  - is_br & funct3 in {010,011}: illegal = 1, taken = 0, target = pc+4, mispredict = 0, no BHT update.
//  - Legal branch: mispredict = pred ^ taken; in RESP update BHT[idx(pc)]: +1 if taken, -1 if not taken.
//    Counter saturates at 2'b11 and 2'b00.
//  - Target arithmetic is modulo 2^XLEN; wrap-around is silent.
//  - idx(x) = x[$clog2(BHT_DEPTH)+1:2]. pred_taken = BHT[idx(pred_pc)][1].
//  - BHT read-before-write: a lookup in the RESP cycle to the entry being updated returns the pre-update value.
//  - rst_n low in any state, including mid EVAL/RESP: request is abandoned, res_valid never asserts, full reset applies.
//  - req_valid while not ready is ignored. The requester holds its inputs until accepted.
// STRUCTURE
//  - branch_pkg: BR_OPCODE, F3_BEQ..F3_BGEU constants, state enum {IDLE,EVAL,RESP}, counter encodings SNT/WNT/WT/ST.
//  - Sub-module branch_cmp: purely combinational; inputs funct3 and two XLEN operands; outputs cond_true and illegal.
//  - Top module holds the FSM, capture registers, adders and the BHT counter array.
// TESTING
//  1. Reset 2 cycles -> res_valid = 0, req_ready = 1, pred_taken = 0 for pred_pc = 0x0, 0x100, 0xFC.
//  2. BEQ rs1 = rs2 = 5, pc = 0x100, imm = 0x20 -> at N+2: taken = 1, target = 0x120, mispredict = 1;
//     afterwards pred_taken(0x100) = 1.
//  3. BLT rs1 = 0xFFFFFFFF, rs2 = 1 -> taken. BLTU with the same operands -> not taken, target = pc+4.
//  4. Four taken BNE at pc = 0x40 -> counter = 11. One not-taken -> mispredict = 1, counter = 10, pred_taken still 1.
//  5. funct3 = 010 -> res_illegal = 1, BHT unchanged. branch = 0 with op = 1100011 -> target pc+4, BHT unchanged.
//  6. pc = 0xFFFFFFFC, imm = 8, taken -> target = 0x4. rst_n = 0 during EVAL -> no res_valid, counters = 01.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants, state encoding and counter helper for the branch resolution unit.
// Imported by branch_cmp and branch_unit.
package branch_pkg;

    localparam logic [6:0] BR_OPCODE = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Two-bit saturating counter step; never wraps past ST or SNT.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        case (cnt)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// B-type condition evaluator: purely combinational, no state, no flow control.
// funct3 010/011 report illegal with cond_true held low.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            cond_true,
    output logic            illegal
);

    always_comb begin
        cond_true = 1'b0;
        illegal   = 1'b0;
        case (funct3)
            F3_BEQ:  cond_true = (a == b);
            F3_BNE:  cond_true = (a != b);
            F3_BLT:  cond_true = ($signed(a) <  $signed(b));
            F3_BGE:  cond_true = ($signed(a) >= $signed(b));
            F3_BLTU: cond_true = (a <  b);
            F3_BGEU: cond_true = (a >= b);
            default: illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution with BHT prediction; result two cycles after accept, one request per three cycles.
// req_ready only in IDLE; the result pulse cannot be stalled and res_* hold until the next result.
module branch_unit
    import branch_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_RESET = WNT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic            branch,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic [XLEN-1:0] res_target,
    output logic            res_mispredict,
    output logic            res_illegal
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef struct packed {
        logic [6:0]      op;
        logic [2:0]      funct3;
        logic            branch;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } req_t;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mispredict;
        logic            illegal;
    } res_t;

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    res_t            res_q, res_d;
    logic            pred_q, pred_d;
    logic            upd_q, upd_d;
    logic [1:0]      bht_q [BHT_DEPTH];
    logic [1:0]      bht_d [BHT_DEPTH];

    logic [IDX_W-1:0] acc_idx, upd_idx, look_idx;
    logic             cond_true, cmp_illegal;
    logic             is_br, legal_br, br_taken;
    logic [XLEN-1:0]  sum_taken, sum_seq;
    logic             unused_pred_bits;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3    (req_q.funct3),
        .a         (req_q.rs1),
        .b         (req_q.rs2),
        .cond_true (cond_true),
        .illegal   (cmp_illegal)
    );

    assign acc_idx  = pc[IDX_W+1:2];
    assign upd_idx  = req_q.pc[IDX_W+1:2];
    assign look_idx = pred_pc[IDX_W+1:2];
    assign unused_pred_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    assign is_br     = (req_q.op == BR_OPCODE) && req_q.branch;
    assign legal_br  = is_br && !cmp_illegal;
    assign br_taken  = legal_br && cond_true;
    assign sum_taken = req_q.pc + req_q.imm;
    assign sum_seq   = req_q.pc + XLEN'(4);

    // Lookup reads the registered array, so an update in RESP is seen only from the next cycle.
    assign pred_taken     = bht_q[look_idx][1];
    assign req_ready      = (state_q == IDLE);
    assign res_valid      = (state_q == RESP);
    assign res_taken      = res_q.taken;
    assign res_target     = res_q.target;
    assign res_mispredict = res_q.mispredict;
    assign res_illegal    = res_q.illegal;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        res_d   = res_q;
        pred_d  = pred_q;
        upd_d   = upd_q;
        bht_d   = bht_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.op     = op;
                    req_d.funct3 = funct3;
                    req_d.branch = branch;
                    req_d.rs1    = rs1_val;
                    req_d.rs2    = rs2_val;
                    req_d.pc     = pc;
                    req_d.imm    = imm;
                    pred_d       = bht_q[acc_idx][1];
                    state_d      = EVAL;
                end
            end
            EVAL: begin
                res_d.taken      = br_taken;
                res_d.target     = br_taken ? sum_taken : sum_seq;
                res_d.mispredict = legal_br && (pred_q ^ br_taken);
                res_d.illegal    = is_br && cmp_illegal;
                upd_d            = legal_br;
                state_d          = RESP;
            end
            RESP: begin
                if (upd_q) begin
                    bht_d[upd_idx] = cnt_next(bht_q[upd_idx], res_q.taken);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            res_q   <= '0;
            pred_q  <= 1'b0;
            upd_q   <= 1'b0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CNT_RESET;
            end
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            res_q   <= res_d;
            pred_q  <= pred_d;
            upd_q   <= upd_d;
            bht_q   <= bht_d;
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: expected results queued at drive time, popped on res_valid.
module tb_branch_unit;
    import branch_pkg::*;

    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        branch = 1'b0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic [31:0] pred_pc = '0;
    logic        pred_taken;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_mispredict;
    logic        res_illegal;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic        ill;
        logic        pre;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    branch_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_RESET(2'b01)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .op             (op),
        .funct3         (funct3),
        .branch         (branch),
        .rs1_val        (rs1_val),
        .rs2_val        (rs2_val),
        .pc             (pc),
        .imm            (imm),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_mispredict (res_mispredict),
        .res_illegal    (res_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] addr, input logic exp);
        pred_pc = addr;
        #1;
        chk(tag, pred_taken, exp);
    endtask

    // Issue one request, then wait (bounded) for its result and score it.
    task automatic send(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic br,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                        input logic [31:0] im, input logic et, input logic [31:0] etg,
                        input logic em, input logic ei, input logic epre);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_ready"}, req_ready, 1'b1);
        op = o; funct3 = f3; branch = br; rs1_val = a; rs2_val = b;
        pc = p; imm = im; pred_pc = p; req_valid = 1'b1;
        sb.push_back('{taken: et, target: etg, mis: em, ill: ei, pre: epre});
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after acceptance so only captured values may matter.
        req_valid = 1'b0; op = ~o; funct3 = ~f3; branch = ~br;
        rs1_val = ~a; rs2_val = a; pc = p ^ 32'h0000_0ff0; imm = ~im;
        cyc = 1;
        while (!res_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 2);
        if (res_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_taken"}, res_taken, e.taken);
            chk({tag, "_target"}, res_target, e.target);
            chk({tag, "_mispredict"}, res_mispredict, e.mis);
            chk({tag, "_illegal"}, res_illegal, e.ill);
            chk({tag, "_rbw_pred"}, pred_taken, e.pre);
            @(negedge clk);
            chk({tag, "_pulse"}, res_valid, 1'b0);
            chk({tag, "_hold"}, res_target, e.target);
        end
    endtask

    initial begin
        int seen;
        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_taken", res_taken, 1'b0);
        chk("rst_target", res_target, 32'h0);
        chk_pred("rst_pred_0", 32'h0, 1'b0);
        chk_pred("rst_pred_100", 32'h100, 1'b0);
        chk_pred("rst_pred_fc", 32'hFC, 1'b0);
        @(negedge clk);

        // 2. BEQ taken, first sighting mispredicts
        send("beq", BR_OPCODE, F3_BEQ, 1'b1, 32'd5, 32'd5, 32'h100, 32'h20,
             1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
        chk_pred("beq_pred_after", 32'h100, 1'b1);
        @(negedge clk);

        // 3. signed vs unsigned compares
        send("blt", BR_OPCODE, F3_BLT, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h208, 32'h10,
             1'b1, 32'h218, 1'b1, 1'b0, 1'b0);
        send("bltu", BR_OPCODE, F3_BLTU, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h20C, 32'h10,
             1'b0, 32'h210, 1'b0, 1'b0, 1'b0);
        send("bge", BR_OPCODE, F3_BGE, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h310, 32'h10,
             1'b0, 32'h314, 1'b0, 1'b0, 1'b0);
        send("bgeu", BR_OPCODE, F3_BGEU, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h314, 32'h100,
             1'b1, 32'h414, 1'b1, 1'b0, 1'b0);

        // 4. train 0x40 to strongly taken, then one not-taken
        send("bne1", BR_OPCODE, F3_BNE, 1'b1, 32'd1, 32'd2, 32'h40, 32'hFFFF_FFF8,
             1'b1, 32'h38, 1'b1, 1'b0, 1'b0);
        send("bne2", BR_OPCODE, F3_BNE, 1'b1, 32'd1, 32'd2, 32'h40, 32'hFFFF_FFF8,
             1'b1, 32'h38, 1'b0, 1'b0, 1'b1);
        send("bne3", BR_OPCODE, F3_BNE, 1'b1, 32'd1, 32'd2, 32'h40, 32'hFFFF_FFF8,
             1'b1, 32'h38, 1'b0, 1'b0, 1'b1);
        send("bne4", BR_OPCODE, F3_BNE, 1'b1, 32'd1, 32'd2, 32'h40, 32'hFFFF_FFF8,
             1'b1, 32'h38, 1'b0, 1'b0, 1'b1);
        send("bne_nt", BR_OPCODE, F3_BNE, 1'b1, 32'd3, 32'd3, 32'h40, 32'hFFFF_FFF8,
             1'b0, 32'h44, 1'b1, 1'b0, 1'b1);
        chk_pred("bne_pred_after", 32'h40, 1'b1);
        @(negedge clk);
        // counter now 10: one more not-taken must flip the prediction
        send("bne_nt2", BR_OPCODE, F3_BNE, 1'b1, 32'd3, 32'd3, 32'h40, 32'hFFFF_FFF8,
             1'b0, 32'h44, 1'b1, 1'b0, 1'b1);
        chk_pred("bne_pred_flip", 32'h40, 1'b0);
        @(negedge clk);

        // 5. illegal and non-branch forms leave the 0x100 counter (10) alone
        send("ill010", BR_OPCODE, 3'b010, 1'b1, 32'd7, 32'd7, 32'h100, 32'h20,
             1'b0, 32'h104, 1'b0, 1'b1, 1'b1);
        send("ill011", BR_OPCODE, 3'b011, 1'b1, 32'd7, 32'd8, 32'h100, 32'h20,
             1'b0, 32'h104, 1'b0, 1'b1, 1'b1);
        send("nobr", BR_OPCODE, F3_BEQ, 1'b0, 32'd9, 32'd9, 32'h100, 32'h20,
             1'b0, 32'h104, 1'b0, 1'b0, 1'b1);
        send("aluop", OP_ALU, F3_BEQ, 1'b1, 32'd9, 32'd9, 32'h100, 32'h20,
             1'b0, 32'h104, 1'b0, 1'b0, 1'b1);
        chk_pred("ill_pred_kept", 32'h100, 1'b1);
        @(negedge clk);

        // 6. target wrap-around, then reset mid-EVAL
        send("wrap", BR_OPCODE, F3_BEQ, 1'b1, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'd8,
             1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
        chk_pred("wrap_pred_after", 32'hFC, 1'b1);
        @(negedge clk);

        op = BR_OPCODE; funct3 = F3_BEQ; branch = 1'b1; rs1_val = 32'd2; rs2_val = 32'd2;
        pc = 32'h80; imm = 32'h40; pred_pc = 32'h80; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_ready", req_ready, 1'b1);
        chk("abort_taken", res_taken, 1'b0);
        chk("abort_target", res_target, 32'h0);
        chk_pred("abort_pred_100", 32'h100, 1'b0);
        chk_pred("abort_pred_fc", 32'hFC, 1'b0);
        chk_pred("abort_pred_208", 32'h208, 1'b0);
        chk("sb_empty", sb.size(), 0);
        @(negedge clk);

        // counters are back at 01: one taken moves the prediction straight back to 1
        send("post_rst", BR_OPCODE, F3_BEQ, 1'b1, 32'd4, 32'd4, 32'h100, 32'h20,
             1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
        chk_pred("post_rst_pred", 32'h100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
